lif_spike_monitor: RTL and testbench

//   Downstream observer for the LIF neuron spike output. Detects spike rising edges, counts them

---
 rtl/lif_spike_monitor.sv | 141 ++++++++++++++
 tb/tb_lif_spike_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_spike_monitor.sv
// Spike-train observer: windowed firing rate, inter-spike interval and burst flag.
// The edge detector samples every cycle; ena freezes measurement state and clear wipes it.
module lif_spike_monitor #(
  parameter int WINDOW    = 64,
  parameter int CNT_W     = 8,
  parameter int ISI_W     = 8,
  parameter int BURST_GAP = 4,
  parameter int BURST_MIN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi,
  output logic             burst
);
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int RUN_W = $clog2(BURST_MIN + 1) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};
  localparam logic [31:0]      GAP_LIM  = 32'(BURST_GAP);
  localparam logic [31:0]      RUN_LIM  = 32'(BURST_MIN);

  typedef enum logic [1:0] {IDLE, CAND, BURST} state_t;

  logic             spike_d_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [CNT_W-1:0] acc_reg;
  logic [ISI_W-1:0] gap_reg;
  logic             seen_reg;
  logic [RUN_W-1:0] run_reg;
  state_t           state_reg;

  logic             edge_det;
  logic             win_end;
  logic             close;
  logic             gap_expired;
  logic [CNT_W-1:0] acc_next;
  logic [ISI_W-1:0] gap_next;
  logic [RUN_W-1:0] run_inc;
  logic [RUN_W-1:0] run_next;
  state_t           state_next;

  assign edge_det    = spike & ~spike_d_reg;
  assign win_end     = (win_cnt_reg == WIN_LAST);
  assign acc_next    = (edge_det && (acc_reg != CNT_MAX)) ? acc_reg + CNT_W'(1) : acc_reg;
  assign gap_next    = edge_det ? ISI_W'(1)
                     : ((gap_reg == ISI_MAX) ? gap_reg : gap_reg + ISI_W'(1));
  // During an edge cycle gap_reg already holds the distance to the previous edge
  assign close       = edge_det & seen_reg & (32'(gap_reg) <= GAP_LIM);
  assign gap_expired = (32'(gap_reg) >= GAP_LIM);
  assign run_inc     = run_reg + RUN_W'(1);

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    case (state_reg)
      IDLE: begin
        if (edge_det) begin
          state_next = CAND;
          run_next   = RUN_W'(1);
        end
      end
      CAND: begin
        if (close) begin
          run_next = run_inc;
          if (32'(run_inc) >= RUN_LIM) state_next = BURST;
        end else if (edge_det) begin
          run_next = RUN_W'(1);
        end else if (gap_expired) begin
          state_next = IDLE;
        end
      end
      BURST: begin
        if (close) begin
          state_next = BURST;
        end else if (edge_det) begin
          state_next = CAND;
          run_next   = RUN_W'(1);
        end else if (gap_expired) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d_reg <= 1'b0;
      win_cnt_reg <= '0;
      acc_reg     <= '0;
      gap_reg     <= '0;
      seen_reg    <= 1'b0;
      run_reg     <= '0;
      state_reg   <= IDLE;
      rate        <= '0;
      rate_valid  <= 1'b0;
      isi         <= '0;
      burst       <= 1'b0;
    end else begin
      spike_d_reg <= spike;
      if (clear) begin
        win_cnt_reg <= '0;
        acc_reg     <= '0;
        gap_reg     <= '0;
        seen_reg    <= 1'b0;
        run_reg     <= '0;
        state_reg   <= IDLE;
        rate        <= '0;
        rate_valid  <= 1'b0;
        isi         <= '0;
        burst       <= 1'b0;
      end else if (ena) begin
        win_cnt_reg <= win_end ? '0 : win_cnt_reg + WIN_W'(1);
        rate_valid  <= win_end;
        if (win_end) begin
          rate    <= acc_next;
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_next;
        end
        gap_reg <= gap_next;
        // The first edge after reset/clear only arms the interval measurement
        if (edge_det) begin
          seen_reg <= 1'b1;
          if (seen_reg) isi <= gap_reg;
        end
        state_reg <= state_next;
        run_reg   <= run_next;
        burst     <= (state_next == BURST);
      end else begin
        rate_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor: a WINDOW=64 instance for most scenarios and a
// WINDOW=1024 instance for rate/ISI saturation.
module tb_lif_spike_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0, clear = 1'b0, spike = 1'b0;
  logic       ena2 = 1'b0, clear2 = 1'b0, spike2 = 1'b0;
  logic [7:0] rate, isi, rate2, isi2;
  logic       rate_valid, burst, rate_valid2, burst2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  lif_spike_monitor #(.WINDOW(64), .CNT_W(8), .ISI_W(8), .BURST_GAP(4), .BURST_MIN(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike(spike),
    .rate(rate), .rate_valid(rate_valid), .isi(isi), .burst(burst)
  );

  lif_spike_monitor #(.WINDOW(1024), .CNT_W(8), .ISI_W(8), .BURST_GAP(4), .BURST_MIN(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .clear(clear2), .spike(spike2),
    .rate(rate2), .rate_valid(rate_valid2), .isi(isi2), .burst(burst2)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (rate !== 8'd0) begin errors++; $display("FAIL reset_rate: got %0d expected 0", rate); end
    else $display("ok   reset_rate = %0d", rate);
    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL reset_rate_valid: got %b expected 0", rate_valid); end
    else $display("ok   reset_rate_valid = %b", rate_valid);
    checks++; if (isi !== 8'd0) begin errors++; $display("FAIL reset_isi: got %0d expected 0", isi); end
    else $display("ok   reset_isi = %0d", isi);
    checks++; if (burst !== 1'b0) begin errors++; $display("FAIL reset_burst: got %b expected 0", burst); end
    else $display("ok   reset_burst = %b", burst);
  endtask

  task automatic test_reset_mid_window();
    int early;
    early = 0;
    ena = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      spike = (i < 10) && (i % 2 == 0);
      tick();
      if (i < 63 && rate_valid) early++;
    end
    checks++; if (rate_valid !== 1'b1 || early != 0) begin errors++; $display("FAIL win1_valid: got %b (early %0d) expected 1 (early 0)", rate_valid, early); end
    else $display("ok   win1_valid = %b", rate_valid);
    checks++; if (rate !== 8'd5) begin errors++; $display("FAIL win1_rate: got %0d expected 5", rate); end
    else $display("ok   win1_rate = %0d", rate);
    for (int i = 0; i < 10; i++) begin
      spike = (i % 2 == 0);
      tick();
    end
    checks++; if (burst !== 1'b1 || isi !== 8'd2) begin errors++; $display("FAIL pre_reset: got burst=%b isi=%0d expected burst=1 isi=2", burst, isi); end
    else $display("ok   pre_reset burst=%b isi=%0d", burst, isi);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rate !== 8'd0 || rate_valid !== 1'b0 || isi !== 8'd0 || burst !== 1'b0) begin
      errors++; $display("FAIL async_reset: got rate=%0d rv=%b isi=%0d burst=%b expected all 0", rate, rate_valid, isi, burst); end
    else $display("ok   async_reset outputs cleared before clock");
    tick();
    rst_n = 1'b1;
    early = 0;
    for (int k = 1; k <= 64; k++) begin
      spike = (k == 1);
      tick();
      if (k < 64 && rate_valid) early++;
    end
    checks++; if (rate_valid !== 1'b1 || early != 0) begin errors++; $display("FAIL post_reset_valid: got %b (early %0d) expected 1 at cycle 64", rate_valid, early); end
    else $display("ok   post_reset_valid at cycle 64");
    checks++; if (rate !== 8'd1) begin errors++; $display("FAIL post_reset_rate: got %0d expected 1", rate); end
    else $display("ok   post_reset_rate = %0d", rate);
    checks++; if (isi !== 8'd0) begin errors++; $display("FAIL first_edge_isi: got %0d expected 0", isi); end
    else $display("ok   first_edge_isi = %0d", isi);
  endtask

  task automatic test_periodic();
    int nvalid, burst_drop;
    nvalid = 0;
    burst_drop = 0;
    for (int i = 0; i < 128; i++) begin
      spike = (i % 4 == 0);
      tick();
      if (rate_valid) nvalid++;
      if (i >= 8 && !burst) burst_drop++;
      if (i == 0) begin
        checks++; if (isi !== 8'd64) begin errors++; $display("FAIL periodic_isi_first: got %0d expected 64", isi); end
        else $display("ok   periodic_isi_first = %0d", isi);
      end
      if (i == 4) begin
        checks++; if (isi !== 8'd4) begin errors++; $display("FAIL periodic_isi: got %0d expected 4", isi); end
        else $display("ok   periodic_isi = %0d", isi);
      end
      if (i == 7) begin
        checks++; if (burst !== 1'b0) begin errors++; $display("FAIL periodic_burst_early: got %b expected 0", burst); end
        else $display("ok   periodic_burst_early = %b", burst);
      end
      if (i == 63 || i == 127) begin
        checks++; if (rate_valid !== 1'b1 || rate !== 8'd16) begin errors++; $display("FAIL periodic_rate@%0d: got rv=%b rate=%0d expected rv=1 rate=16", i, rate_valid, rate); end
        else $display("ok   periodic_rate@%0d = %0d", i, rate);
      end
    end
    checks++; if (nvalid != 2 || burst_drop != 0) begin errors++; $display("FAIL periodic_pulses: got valid=%0d burst_drop=%0d expected 2 and 0", nvalid, burst_drop); end
    else $display("ok   periodic_pulses valid=%0d burst held", nvalid);
  endtask

  task automatic test_held_and_slow();
    int burst_seen;
    burst_seen = 0;
    for (int i = 0; i < 64; i++) begin
      spike = (i < 10);
      tick();
    end
    checks++; if (rate_valid !== 1'b1 || rate !== 8'd1) begin errors++; $display("FAIL held_rate: got rv=%b rate=%0d expected rv=1 rate=1", rate_valid, rate); end
    else $display("ok   held_rate = %0d", rate);
    for (int i = 0; i < 64; i++) begin
      spike = (i % 8 == 0);
      tick();
      if (burst) burst_seen++;
    end
    checks++; if (rate !== 8'd8 || isi !== 8'd8) begin errors++; $display("FAIL slow_rate_isi: got rate=%0d isi=%0d expected 8 and 8", rate, isi); end
    else $display("ok   slow rate=%0d isi=%0d", rate, isi);
    checks++; if (burst_seen != 0) begin errors++; $display("FAIL slow_burst: got %0d burst cycles expected 0", burst_seen); end
    else $display("ok   slow_burst none");
  endtask

  task automatic test_burst_decay();
    for (int j = 0; j <= 8; j++) begin
      spike = (j == 0 || j == 2 || j == 4);
      tick();
      if (j == 2) begin
        checks++; if (burst !== 1'b0 || isi !== 8'd2) begin errors++; $display("FAIL decay_two_edges: got burst=%b isi=%0d expected 0 and 2", burst, isi); end
        else $display("ok   decay_two_edges burst=%b isi=%0d", burst, isi);
      end
      if (j == 4 || j == 7) begin
        checks++; if (burst !== 1'b1) begin errors++; $display("FAIL decay_burst@%0d: got %b expected 1", j, burst); end
        else $display("ok   decay_burst@%0d = %b", j, burst);
      end
      if (j == 8) begin
        checks++; if (burst !== 1'b0) begin errors++; $display("FAIL decay_fall: got %b expected 0", burst); end
        else $display("ok   decay_fall = %b", burst);
      end
    end
  endtask

  task automatic test_clear_and_pause();
    int nvalid;
    spike = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (rate !== 8'd0 || isi !== 8'd0 || burst !== 1'b0) begin errors++; $display("FAIL clear_outputs: got rate=%0d isi=%0d burst=%b expected 0", rate, isi, burst); end
    else $display("ok   clear_outputs zero");
    for (int i = 0; i < 64; i++) begin
      spike = (i == 0 || i == 2 || i == 4 || i == 6);
      tick();
      if (i == 0) begin
        checks++; if (isi !== 8'd0) begin errors++; $display("FAIL clear_first_edge_isi: got %0d expected 0", isi); end
        else $display("ok   clear_first_edge_isi = %0d", isi);
      end
    end
    checks++; if (rate_valid !== 1'b1 || rate !== 8'd4) begin errors++; $display("FAIL clear_win_rate: got rv=%b rate=%0d expected rv=1 rate=4", rate_valid, rate); end
    else $display("ok   clear_win_rate = %0d", rate);
    for (int i = 0; i < 64; i++) begin
      spike = (i == 57 || i == 59 || i == 61 || i == 63);
      clear = (i == 63);
      tick();
      if (i == 62) begin
        checks++; if (burst !== 1'b1 || isi !== 8'd2) begin errors++; $display("FAIL pre_clear: got burst=%b isi=%0d expected 1 and 2", burst, isi); end
        else $display("ok   pre_clear burst=%b isi=%0d", burst, isi);
      end
    end
    clear = 1'b0;
    checks++; if (rate_valid !== 1'b0 || rate !== 8'd0 || isi !== 8'd0 || burst !== 1'b0) begin
      errors++; $display("FAIL clear_at_window_end: got rv=%b rate=%0d isi=%0d burst=%b expected all 0", rate_valid, rate, isi, burst); end
    else $display("ok   clear_at_window_end suppressed");
    nvalid = 0;
    for (int i = 0; i < 84; i++) begin
      ena = !(i >= 10 && i < 30);
      spike = (i == 5 || i == 15 || i == 40);
      tick();
      if (i < 83 && rate_valid) nvalid++;
    end
    checks++; if (rate_valid !== 1'b1 || nvalid != 0) begin errors++; $display("FAIL pause_window: got rv=%b early=%0d expected rv=1 early=0", rate_valid, nvalid); end
    else $display("ok   pause_window stretched by 20");
    checks++; if (rate !== 8'd2 || isi !== 8'd15) begin errors++; $display("FAIL pause_rate_isi: got rate=%0d isi=%0d expected 2 and 15", rate, isi); end
    else $display("ok   pause rate=%0d isi=%0d", rate, isi);
    ena = 1'b0;
    spike = 1'b0;
    tick();
    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL ena_low_valid: got %b expected 0", rate_valid); end
    else $display("ok   ena_low_valid = %b", rate_valid);
    ena = 1'b1;
  endtask

  task automatic test_saturation();
    ena2 = 1'b1;
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      spike2 = (i % 2 == 0);
      tick();
      if (i == 100) begin
        checks++; if (isi2 !== 8'd2) begin errors++; $display("FAIL sat_toggle_isi: got %0d expected 2", isi2); end
        else $display("ok   sat_toggle_isi = %0d", isi2);
      end
    end
    checks++; if (rate_valid2 !== 1'b1 || rate2 !== 8'd255) begin errors++; $display("FAIL sat_rate: got rv=%b rate=%0d expected rv=1 rate=255", rate_valid2, rate2); end
    else $display("ok   sat_rate = %0d", rate2);
    checks++; if (burst2 !== 1'b1) begin errors++; $display("FAIL sat_burst: got %b expected 1", burst2); end
    else $display("ok   sat_burst = %b", burst2);
    spike2 = 1'b0;
    repeat (300) tick();
    spike2 = 1'b1;
    tick();
    checks++; if (isi2 !== 8'd255 || burst2 !== 1'b0) begin errors++; $display("FAIL sat_isi: got isi=%0d burst=%b expected 255 and 0", isi2, burst2); end
    else $display("ok   sat_isi = %0d", isi2);
  endtask

  initial begin
    test_reset();
    test_reset_mid_window();
    test_periodic();
    test_held_and_slow();
    test_burst_decay();
    test_clear_and_pause();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
